// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline: merges per-stage stall requests,
// runs the freeze-then-flush exception sequence and counts stalled cycles.
module pipeline_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreqIF_i,
    input  logic        stallreqID_i,
    input  logic        stallreqEX_i,
    input  logic        stallreqMEM_i,
    input  logic        flushReq_i,
    input  logic [31:0] excAddr_i,
    input  logic        perfClr_i,
    output logic [5:0]  stall_o,
    output logic        flush_o,
    output logic [31:0] newPC_o,
    output logic [1:0]  state_o,
    output logic [31:0] stallCycles_o
);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_FREEZE = 2'd1;
    localparam logic [1:0] ST_FLUSH  = 2'd2;
    localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

    logic [1:0]  state_q, state_d;
    logic [3:0]  fcnt_q, fcnt_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [5:0]  stall_vec;

    // Later stages dominate; an exception freezes everything, including WB.
    always_comb begin
        stall_vec = 6'b000000;
        case (state_q)
            ST_RUN: begin
                if (flushReq_i)         stall_vec = 6'b111111;
                else if (stallreqMEM_i) stall_vec = 6'b011111;
                else if (stallreqEX_i)  stall_vec = 6'b001111;
                else if (stallreqID_i)  stall_vec = 6'b000111;
                else if (stallreqIF_i)  stall_vec = 6'b000011;
                else                    stall_vec = 6'b000000;
            end
            ST_FREEZE: stall_vec = 6'b111111;
            default:   stall_vec = 6'b000000;
        endcase
    end

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        epc_d   = epc_q;
        case (state_q)
            ST_RUN: begin
                if (flushReq_i) begin
                    epc_d   = excAddr_i;
                    state_d = ST_FREEZE;
                end
            end
            ST_FREEZE: begin
                state_d = ST_FLUSH;
                fcnt_d  = FLUSH_LAST;
            end
            ST_FLUSH: begin
                // Further exceptions are dropped: they come from squashed instructions.
                if (fcnt_q == 4'd0) state_d = ST_RUN;
                else                fcnt_d  = fcnt_q - 4'd1;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (perfClr_i)              stall_cnt_d = 32'd0;
        else if (stall_vec != 6'd0) stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_RUN;
            fcnt_q      <= 4'd0;
            epc_q       <= 32'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            fcnt_q      <= fcnt_d;
            epc_q       <= epc_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // All outputs read as zero for as long as reset is held.
    assign stall_o       = rst ? stall_vec : 6'd0;
    assign flush_o       = rst && (state_q == ST_FLUSH);
    assign newPC_o       = (rst && (state_q == ST_FLUSH)) ? epc_q : 32'd0;
    assign state_o       = rst ? state_q : ST_RUN;
    assign stallCycles_o = rst ? stall_cnt_q : 32'd0;

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush sequencer for the five-stage MIPS32 pipeline. It collects stall requests from IF, ID (load-use), EX (multi-cycle ops) and MEM, and drives one stall vector that freezes the PC and the pipeline registers. It runs a multi-cycle flush sequence on exceptions and supplies the redirect PC. It also keeps a stall-cycle performance counter. It sits beside the datapath and feeds the PC register and every inter-stage register (IF/ID, ID/EX, EX/MEM, MEM/WB).

## Interface
- FLUSH_CYCLES, default 2: number of cycles `flush_o` stays high per exception, legal range 1–15.
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous and active-low.
- stallreqIF_i  in  1  instruction fetch not ready.
- stallreqID_i  in  1  load-use hazard detected in ID.
- stallreqEX_i  in  1  multi-cycle EX operation busy.
- stallreqMEM_i  in  1  data memory not ready.
- flushReq_i  in  1  exception raised in MEM.
- excAddr_i  in  32  handler address, valid with `flushReq_i`.
- perfClr_i  in  1  clear the stall counter.
- stall_o  out  6  freeze bits: [0] PC, [1] IF/ID, [2] ID/EX, [3] EX/MEM, [4] MEM/WB, [5] WB.
- flush_o  out  1  invalidate all pipeline registers.
- newPC_o  out  32  redirect target, meaningful while `flush_o`=1.
- state_o  out  2  FSM state: 0 RUN, 1 FREEZE, 2 FLUSH.
- stallCycles_o  out  32  count of cycles with `stall_o` ≠ 0.

## Operation
- **Reset** (`rst`=0 at a clock edge):
  - state ← RUN, flush counter ← 0, latched PC ← 0, `stallCycles_o` ← 0.
  - While reset is held, all outputs are forced to 0.
  - Reset mid-FREEZE or mid-FLUSH aborts the sequence with no further flush pulses.
- **RUN**: `stall_o` is combinational from the requests. The highest stage wins:
  - MEM → 6'b011111
  - else EX → 6'b001111
  - else ID → 6'b000111
  - else IF → 6'b000011
  - else 6'b000000
  - `flush_o`=0 and `newPC_o`=0.
- **RUN + `flushReq_i`=1**: flush beats every stall request.
  - In the same cycle, `stall_o`=6'b111111.
  - At the edge: `excAddr_i` is latched, and state ← FREEZE.
- **FREEZE**: lasts exactly one cycle.
  - `stall_o`=6'b111111, `flush_o`=0.
  - Lets MEM's exception state settle.
  - Next state: FLUSH, with counter ← FLUSH_CYCLES−1.
- **FLUSH**:
  - `flush_o`=1, `newPC_o`=latched address, `stall_o`=0.
  - The counter decrements each cycle. When it reaches 0, next state is RUN.
- **Requests ignored outside RUN**: in FREEZE and FLUSH, all stall requests and `flushReq_i` are ignored. A second exception is not queued, because it belongs to a squashed instruction.
- **Stall counter**:
  - +1 on every edge where `stall_o` ≠ 0, including FREEZE.
  - Wraps from 32'hFFFFFFFF to 0.
  - `perfClr_i`=1 sets it to 0 and takes priority over the increment.
- **Stall vector shape**: `stall_o` is always a contiguous run of ones starting at bit 0, or all zero.

## Timing
- Stall response has zero latency: a request in cycle N appears in `stall_o` in cycle N.
- Exception sampled at edge N:
  - FREEZE occupies cycle N+1.
  - `flush_o`=1 for cycles N+2 … N+1+FLUSH_CYCLES.
  - RUN resumes at cycle N+2+FLUSH_CYCLES.
  - First instruction fetched from the handler: the cycle after the last `flush_o` cycle.
- `state_o`, `newPC_o`, `flush_o` and `stallCycles_o` are registered or pure decodes of registered state. Only `stall_o` in RUN has a combinational path from the inputs.
- No combinational path exists from `excAddr_i` to any output.

## Test plan
- **Reset:** hold `rst`=0 for 3 cycles with all requests high → every output 0 and `state_o`=0. Release → RUN, and `stall_o` follows the requests next cycle.
- **Stall priority:** drive IF=1 → 6'b000011. Add ID → 6'b000111. Add EX → 6'b001111. Add MEM → 6'b011111. Drop all → 0, with no cycle of latency at any step.
- **Exception:** with FLUSH_CYCLES=2, pulse `flushReq_i` with `excAddr_i`=32'h00000380 alongside `stallreqEX_i`=1.
  - Request cycle: `stall_o`=6'b111111.
  - Next cycle: FREEZE, 6'b111111.
  - Next two cycles: `flush_o`=1, `newPC_o`=32'h00000380.
  - Then RUN, and `stall_o`=6'b001111 if EX is still requesting.
- **Second exception:** re-assert `flushReq_i` during FREEZE and during FLUSH with `excAddr_i`=32'hDEADBEEF → ignored. Exactly 2 flush cycles occur and `newPC_o` stays 32'h00000380.
- **Reset mid-FLUSH:** `rst`=0 in the first FLUSH cycle → next cycle `flush_o`=0, state RUN, counter 0, and no further flush pulses after release.
- **Perf counter:**
  - 5 stalled cycles → `stallCycles_o`=5.
  - Preload by 2^32−1 stalled cycles (or force) → one more stall reads 0.
  - `perfClr_i` together with a stall → 0.
